// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: FSM encoding,
// opcodes the fetch unit pre-decodes, and the fetch timeout limit.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [7:0] FETCH_TIMEOUT_MAX = 8'd255;

    function automatic logic [3:0] opcode_of(input logic [15:0] word);
        return word[15:12];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Multi-cycle req/ack instruction memory bus between the fetch unit (master)
// and instruction memory (slave).
interface instr_fetch_unit_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;

    modport master (output mem_req, mem_addr, input  mem_ack, mem_data);
    modport slave  (input  mem_req, mem_addr, output mem_ack, mem_data);
endinterface

// File: rtl/instr_fetch_unit_imm_sext9.sv
// 9-bit to 16-bit sign extender for the B-instruction branch offset.
module imm_sext9 (
    input  logic [8:0]  imm,
    output logic [15:0] ext
);
    assign ext = {{7{imm[8]}}, imm};
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: latches PC, runs a req/ack memory read, holds
// the instruction for decode and pre-decodes branch fields. Optional fetch
// timeout is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                pc,
    input  logic                       stall,
    input  logic                       flush,
    instr_fetch_unit_if.master         mem,
    output logic [15:0]                instr,
    output logic                       instr_valid,
    output logic                       pc_advance,
    output logic                       is_branch,
    output logic [2:0]                 br_cond,
    output logic [15:0]                br_offset,
    output logic                       halted,
    output logic                       fetch_err
);

    fetch_state_t state_q, state_d;
    logic [15:0]  mem_addr_q;
    logic         drop_q, drop_d;
    logic         addr_wait_q, addr_wait_d;
    logic         load_addr, capture, req_active, adv, timeout_hit, timeout_fire;
    logic [3:0]   opcode;
    logic [15:0]  sext_off;

    assign opcode = opcode_of(instr);

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        addr_wait_d  = addr_wait_q;
        load_addr    = 1'b0;
        capture      = 1'b0;
        req_active   = 1'b0;
        adv          = 1'b0;
        timeout_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                load_addr = 1'b1;
                state_d   = S_REQ;
            end
            S_REQ: begin
                if (addr_wait_q) begin
                    // Address-load cycle after VALID: the PC updater has just
                    // loaded, so sample pc now and hold off the request.
                    load_addr   = 1'b1;
                    addr_wait_d = 1'b0;
                    if (flush) state_d = S_IDLE;
                end else begin
                    req_active = 1'b1;
                    if (mem.mem_ack) begin
                        drop_d = 1'b0;
                        if (drop_q || flush) begin
                            state_d = S_IDLE;
                        end else begin
                            capture = 1'b1;
                            state_d = S_VALID;
                        end
                    end else begin
                        // Request must stay up until ack, so a flush only marks
                        // the returning data for discard.
                        if (flush) drop_d = 1'b1;
                        if (timeout_hit) begin
                            timeout_fire = 1'b1;
                            state_d      = S_HALT;
                        end
                    end
                end
            end
            S_VALID: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (!stall) begin
                    adv = 1'b1;
                    if (opcode == OP_HLT) begin
                        state_d = S_HALT;
                    end else begin
                        addr_wait_d = 1'b1;
                        state_d     = S_REQ;
                    end
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            instr       <= '0;
            drop_q      <= 1'b0;
            addr_wait_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            addr_wait_q <= addr_wait_d;
            if (load_addr) mem_addr_q <= pc;
            if (capture)   instr      <= mem.mem_data;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;
    logic       fetch_err_q;

    assign timeout_hit = (tmo_cnt_q == FETCH_TIMEOUT_MAX - 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q   <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= (req_active && !mem.mem_ack) ? tmo_cnt_q + 8'd1 : 8'd0;
            if (timeout_fire) fetch_err_q <= 1'b1;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    assign mem.mem_req  = req_active;
    assign mem.mem_addr = mem_addr_q;
    assign instr_valid  = (state_q == S_VALID);
    assign pc_advance   = adv;
    assign halted       = (state_q == S_HALT);

    imm_sext9 u_sext (
        .imm (instr[8:0]),
        .ext (sext_off)
    );

    assign is_branch = (opcode == OP_B) || (opcode == OP_BR);
    assign br_cond   = instr[11:9];
    assign br_offset = (opcode == OP_B) ? sext_off : 16'h0000;

endmodule
